// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the serial pattern detector.
// The optional match counter is controlled by SEQ_DET_MATCH_CNT_EN.
package seq_det_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Bits needed to hold a fill count of 0..pat_w inclusive.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Instantiated by seq_detect_param only when SEQ_DET_MATCH_CNT_EN is defined.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with overlap/non-overlap modes and a registered match pulse.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_in,
  input  logic             d_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             overlap_en,
  input  logic             clr_cnt,
  output logic             q_out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = fill_w(PAT_W);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [FW-1:0]    fill_inc;
  logic             q_q, q_d;
  logic             match;

  always_comb begin
    pat_d    = pat_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    q_d      = 1'b0;
    match    = 1'b0;
    fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    if (cfg_load) begin
      // A bit arriving with the load is dropped so the new pattern starts clean.
      pat_d  = pattern_in;
      hist_d = '0;
      fill_d = '0;
    end else if (d_valid) begin
      hist_d = {hist_q[PAT_W-2:0], d_in};
      fill_d = fill_inc;
      if ((fill_inc == FILL_FULL) && (hist_d == pat_q)) begin
        match  = 1'b1;
        q_d    = 1'b1;
        fill_d = overlap_en ? FILL_FULL : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
      q_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      q_q    <= q_d;
    end
  end

  assign q_out = q_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (clr_cnt),
    .count(match_cnt)
  );
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = clr_cnt ^ match;
  assign match_cnt = '0;
`endif

endmodule
